// File: rtl/gate_mon_pkg.sv
// Shared encodings for the gate drive monitor: leg FSM states, fault-type bits, leg indices.
package gate_mon_pkg;

  typedef enum logic [2:0] {
    L_IDLE   = 3'd0,
    L_UP     = 3'd1,
    L_DN     = 3'd2,
    L_DEAD_U = 3'd3,
    L_DEAD_D = 3'd4
  } leg_state_t;

  localparam int FT_SHOOT = 0;
  localparam int FT_DEAD  = 1;

  localparam int LEG_BUCK1 = 0;
  localparam int LEG_BUCK2 = 1;
  localparam int LEG_RES1  = 2;
  localparam int LEG_RES2  = 3;
  localparam int NUM_LEGS  = 4;

endpackage

// File: rtl/gate_leg_checker.sv
// One half-bridge leg checker: flags shoot-through entries and dead-time violations on a registered {up, down} command.
// Latency: events are combinational from the registered command; no backpressure (passive observer).
module gate_leg_checker
  import gate_mon_pkg::*;
#(
  parameter logic [15:0] DEAD_TIME_MIN = 16'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] gate,
  output logic       shoot_evt,
  output logic       dead_evt
);

  leg_state_t  state, state_nxt;
  logic [15:0] dcnt, dcnt_nxt;
  logic        shoot_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= L_IDLE;
      dcnt       <= '0;
      shoot_hold <= 1'b0;
    end else begin
      state      <= state_nxt;
      dcnt       <= dcnt_nxt;
      shoot_hold <= (gate == 2'b11);
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    shoot_evt = 1'b0;
    dead_evt  = 1'b0;
    // Both devices on overrides everything; only the first cycle of a run is an event.
    if (gate == 2'b11) begin
      shoot_evt = !shoot_hold;
      state_nxt = L_IDLE;
      dcnt_nxt  = '0;
    end else begin
      case (state)
        L_IDLE: begin
          if (gate == 2'b10)      state_nxt = L_UP;
          else if (gate == 2'b01) state_nxt = L_DN;
        end
        L_UP: begin
          if (gate == 2'b00) begin
            state_nxt = L_DEAD_U;
            dcnt_nxt  = 16'd1;
          end else if (gate == 2'b01) begin
            dead_evt  = 1'b1;
            state_nxt = L_DN;
          end
        end
        L_DN: begin
          if (gate == 2'b00) begin
            state_nxt = L_DEAD_D;
            dcnt_nxt  = 16'd1;
          end else if (gate == 2'b10) begin
            dead_evt  = 1'b1;
            state_nxt = L_UP;
          end
        end
        L_DEAD_U: begin
          if (gate == 2'b00) begin
            dcnt_nxt = dcnt + 16'd1;
            if (dcnt + 16'd1 >= DEAD_TIME_MIN) begin
              state_nxt = L_IDLE;
              dcnt_nxt  = '0;
            end
          end else if (gate == 2'b10) begin
            state_nxt = L_UP;
          end else begin
            dead_evt  = (dcnt < DEAD_TIME_MIN);
            state_nxt = L_DN;
          end
        end
        L_DEAD_D: begin
          if (gate == 2'b00) begin
            dcnt_nxt = dcnt + 16'd1;
            if (dcnt + 16'd1 >= DEAD_TIME_MIN) begin
              state_nxt = L_IDLE;
              dcnt_nxt  = '0;
            end
          end else if (gate == 2'b01) begin
            state_nxt = L_DN;
          end else begin
            dead_evt  = (dcnt < DEAD_TIME_MIN);
            state_nxt = L_UP;
          end
        end
        default: state_nxt = L_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/gate_drive_monitor.sv
// Gate command bus checker: sticky fault + gate kill, saturating fault counters, deion pulse counter; 2 edges port->fault.
// No backpressure (passive observer). Optional per-pulse peak current tracker enabled by GATE_MON_PEAK_EN.
module gate_drive_monitor
  import gate_mon_pkg::*;
#(
  parameter logic [15:0] DEAD_TIME_MIN = 16'd10,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       gate_buck1,
  input  logic [1:0]       gate_buck2,
  input  logic [1:0]       gate_res1,
  input  logic [1:0]       gate_res2,
  input  logic             gate_deion,
  input  logic [15:0]      sample_current,
  input  logic             fault_clear,
  output logic             fault,
  output logic             gate_kill,
  output logic [3:0]       fault_leg,
  output logic [1:0]       fault_type,
  output logic [CNT_W-1:0] shoot_cnt,
  output logic [CNT_W-1:0] dead_viol_cnt,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic [15:0]      peak_current,
  output logic             peak_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_LEGS-1:0][1:0] leg_s1;
  logic                     deion_s1, deion_d;
  logic [NUM_LEGS-1:0]      shoot_v, dead_v, leg_evt;
  logic [1:0]               evt_type;
  logic                     any_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leg_s1   <= '0;
      deion_s1 <= 1'b0;
      deion_d  <= 1'b0;
    end else begin
      leg_s1[LEG_BUCK1] <= gate_buck1;
      leg_s1[LEG_BUCK2] <= gate_buck2;
      leg_s1[LEG_RES1]  <= gate_res1;
      leg_s1[LEG_RES2]  <= gate_res2;
      deion_s1          <= gate_deion;
      deion_d           <= deion_s1;
    end
  end

  for (genvar i = 0; i < NUM_LEGS; i++) begin : g_leg
    gate_leg_checker #(.DEAD_TIME_MIN(DEAD_TIME_MIN)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .gate      (leg_s1[i]),
      .shoot_evt (shoot_v[i]),
      .dead_evt  (dead_v[i])
    );
  end

  assign leg_evt = shoot_v | dead_v;
  assign any_evt = |leg_evt;

  always_comb begin
    evt_type           = '0;
    evt_type[FT_SHOOT] = |shoot_v;
    evt_type[FT_DEAD]  = |dead_v;
  end

  // A clear only takes effect in a cycle with no new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault      <= 1'b0;
      fault_leg  <= '0;
      fault_type <= '0;
    end else if (any_evt) begin
      fault      <= 1'b1;
      fault_leg  <= fault_leg | leg_evt;
      fault_type <= fault_type | evt_type;
    end else if (fault_clear) begin
      fault      <= 1'b0;
      fault_leg  <= '0;
      fault_type <= '0;
    end
  end

  assign gate_kill = fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shoot_cnt     <= '0;
      dead_viol_cnt <= '0;
      pulse_cnt     <= '0;
    end else begin
      if (|shoot_v && shoot_cnt != CNT_MAX)   shoot_cnt     <= shoot_cnt + CNT_W'(1);
      if (|dead_v && dead_viol_cnt != CNT_MAX) dead_viol_cnt <= dead_viol_cnt + CNT_W'(1);
      if (deion_s1 && !deion_d)               pulse_cnt     <= pulse_cnt + CNT_W'(1);
    end
  end

`ifdef GATE_MON_PEAK_EN
  logic signed [15:0] samp_s1, trk;
  logic               armed;

  // Arming on the first low cycle means a deion already high out of reset yields no strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_s1      <= '0;
      trk          <= 16'sh8000;
      armed        <= 1'b0;
      peak_current <= '0;
      peak_valid   <= 1'b0;
    end else begin
      samp_s1    <= sample_current;
      peak_valid <= 1'b0;
      if (!deion_s1) begin
        armed <= 1'b1;
        trk   <= (!armed || samp_s1 > trk) ? samp_s1 : trk;
      end else if (armed) begin
        armed        <= 1'b0;
        peak_current <= trk;
        peak_valid   <= 1'b1;
      end
    end
  end
`else
  logic unused_sample;
  assign unused_sample = ^sample_current;
  assign peak_current  = '0;
  assign peak_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_gate_drive_monitor.sv
// Scoreboard bench for gate_drive_monitor: randomized and directed gate traffic against a leg-history reference model.
module tb_gate_drive_monitor;

  localparam int CW   = 8;
  localparam int DT   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    gate_buck1 = '0, gate_buck2 = '0, gate_res1 = '0, gate_res2 = '0;
  logic          gate_deion = 1'b0;
  logic [15:0]   sample_current = '0;
  logic          fault_clear = 1'b0;
  logic          fault, gate_kill, peak_valid;
  logic [3:0]    fault_leg;
  logic [1:0]    fault_type;
  logic [CW-1:0] shoot_cnt, dead_viol_cnt, pulse_cnt;
  logic [15:0]   peak_current;

  always #5 clk = ~clk;

  gate_drive_monitor #(.DEAD_TIME_MIN(16'(DT)), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .gate_buck1(gate_buck1), .gate_buck2(gate_buck2), .gate_res1(gate_res1), .gate_res2(gate_res2),
    .gate_deion(gate_deion), .sample_current(sample_current), .fault_clear(fault_clear),
    .fault(fault), .gate_kill(gate_kill), .fault_leg(fault_leg), .fault_type(fault_type),
    .shoot_cnt(shoot_cnt), .dead_viol_cnt(dead_viol_cnt), .pulse_cnt(pulse_cnt),
    .peak_current(peak_current), .peak_valid(peak_valid)
  );

  typedef struct packed {
    logic          fault;
    logic [3:0]    leg;
    logic [1:0]    ftype;
    logic [CW-1:0] shoot;
    logic [CW-1:0] dead;
    logic [CW-1:0] pulse;
    logic [15:0]   peak;
    logic          pv;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] peak_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference model: per leg, which device was last on and how many all-off cycles followed.
  int          m_last[4];
  int          m_off[4];
  bit          m_in11[4];
  bit          m_fault;
  bit [3:0]    m_leg;
  bit [1:0]    m_type;
  int          m_shoot, m_dead, m_pulse;
  bit          m_prev_deion;
  int          m_samples[$];
  logic [15:0] m_peak = '0;

  logic [7:0]  d1_g = '0, d2_g = '0;
  logic        d1_deion = 1'b0, d2_deion = 1'b0, d1_clr = 1'b0;
  logic [15:0] d1_s = '0, d2_s = '0;

  task automatic model_step();
    bit [3:0]   sh, dv;
    logic [1:0] g;
    int         dev, mx;
    bit         pv;
    pv = 0;
    for (int i = 0; i < 4; i++) begin
      g = d2_g[2*i +: 2];
      sh[i] = 0;
      dv[i] = 0;
      if (g == 2'b11) begin
        sh[i] = !m_in11[i];
        m_last[i] = 0;
        m_off[i] = 0;
      end else if (g == 2'b00) begin
        if (m_off[i] < DT) m_off[i]++;
      end else begin
        dev = (g == 2'b10) ? 1 : 2;
        if (m_last[i] != 0 && m_last[i] != dev && m_off[i] < DT) dv[i] = 1;
        m_last[i] = dev;
        m_off[i] = 0;
      end
      m_in11[i] = (g == 2'b11);
    end
    if ((sh | dv) != 0) begin
      m_fault = 1;
      m_leg |= sh | dv;
      if (sh != 0) m_type[0] = 1;
      if (dv != 0) m_type[1] = 1;
    end else if (d1_clr) begin
      m_fault = 0;
      m_leg = 0;
      m_type = 0;
    end
    if (sh != 0 && m_shoot < CMAX) m_shoot++;
    if (dv != 0 && m_dead < CMAX) m_dead++;
    if (d2_deion && !m_prev_deion) m_pulse = (m_pulse + 1) % (CMAX + 1);
    m_prev_deion = d2_deion;
`ifdef GATE_MON_PEAK_EN
    if (!d2_deion) m_samples.push_back($signed(d2_s));
    else if (m_samples.size() > 0) begin
      mx = m_samples[0];
      foreach (m_samples[k]) if (m_samples[k] > mx) mx = m_samples[k];
      m_peak = mx[15:0];
      pv = 1;
      peak_q.push_back(m_peak);
      m_samples.delete();
    end
`endif
    exp_q.push_back({m_fault, m_leg, m_type, m_shoot[CW-1:0], m_dead[CW-1:0], m_pulse[CW-1:0], m_peak, pv});
  endtask

  task automatic step(input logic [7:0] g, input logic deion, input logic [15:0] s, input logic clr);
    @(posedge clk);
    #1;
    model_step();
    d2_g = d1_g; d2_deion = d1_deion; d2_s = d1_s;
    {gate_res2, gate_res1, gate_buck2, gate_buck1} = g;
    gate_deion = deion; sample_current = s; fault_clear = clr;
    d1_g = g; d1_deion = deion; d1_s = s; d1_clr = clr;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(8'h00, 1'b0, 16'h0000, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {fault, fault_leg, fault_type, shoot_cnt, dead_viol_cnt, pulse_cnt, peak_current, peak_valid}, e);
        check("gate_kill", gate_kill, e.fault);
        if (peak_valid && peak_q.size() > 0) check("peak_value", peak_current, peak_q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int pk[3];
    logic [7:0] rg;
    logic rd;
    int r;
    pk[0] = 120; pk[1] = -5; pk[2] = 300;
    for (int i = 0; i < 4; i++) begin m_last[i] = 0; m_off[i] = 0; m_in11[i] = 0; end

    #23;
    check("reset_outputs", {fault, fault_leg, fault_type, shoot_cnt, dead_viol_cnt, pulse_cnt, peak_current, peak_valid}, 0);
    check("reset_gate_kill", gate_kill, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(4);

    // Three discharge pulses with known per-pulse peaks.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 6; k++) begin
        r = (k == 3) ? pk[p] : pk[p] - 1 - int'($urandom_range(500));
        step(8'h00, 1'b0, 16'(r), 1'b0);
      end
      for (int k = 0; k < 4; k++) step(8'h00, 1'b1, 16'($urandom), 1'b0);
    end
    idle(3);
    check("pulse_cnt_3", pulse_cnt, 3);

    // Legal buck1 sequence with exactly the minimum dead time.
    for (int k = 0; k < 40; k++) step(8'h02, 1'b0, 16'h0, 1'b0);
    idle(10);
    for (int k = 0; k < 3; k++) step(8'h01, 1'b0, 16'h0, 1'b0);
    idle(3);
    check("legal_fault", fault, 0);
    check("legal_shoot_cnt", shoot_cnt, 0);
    check("legal_dead_cnt", dead_viol_cnt, 0);

    // res1 dead time too short.
    for (int k = 0; k < 3; k++) step(8'h20, 1'b0, 16'h0, 1'b0);
    idle(5);
    step(8'h10, 1'b0, 16'h0, 1'b0);
    idle(3);
    check("dead_fault", fault, 1);
    check("dead_fault_leg", fault_leg, 4'b0100);
    check("dead_fault_type", fault_type, 2'b10);
    check("dead_cnt_1", dead_viol_cnt, 1);

    // buck2 held in shoot-through for 7 cycles counts once.
    for (int k = 0; k < 7; k++) step(8'h0C, 1'b0, 16'h0, 1'b0);
    idle(3);
    check("shoot_cnt_1", shoot_cnt, 1);
    check("shoot_type_bit", fault_type[0], 1);
    check("shoot_gate_kill", gate_kill, 1);

    step(8'h00, 1'b0, 16'h0, 1'b1);
    idle(3);
    check("clear_fault", {fault, fault_leg, fault_type}, 0);
    check("clear_keeps_cnt", shoot_cnt, 1);

    // Clear collides with simultaneous buck1 + res2 shoot-through.
    step(8'hC3, 1'b0, 16'h0, 1'b0);
    step(8'h00, 1'b0, 16'h0, 1'b1);
    idle(3);
    check("collide_fault", fault, 1);
    check("collide_fault_leg", fault_leg, 4'b1001);
    check("collide_shoot_cnt", shoot_cnt, 2);

    // Randomized traffic.
    rg = '0; rd = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) begin
          r = int'($urandom_range(15));
          rg[2*i +: 2] = (r == 0) ? 2'b11 : (r < 6) ? 2'b10 : (r < 11) ? 2'b01 : 2'b00;
        end
      end
      if ($urandom_range(9) == 0) rd = ~rd;
      step(rg, rd, 16'($urandom), ($urandom_range(19) == 0));
    end
    idle(DT + 2);

    // Saturate shoot_cnt, then one more event.
    for (int k = 0; k < 600 && m_shoot < CMAX; k++) step((k % 2 == 0) ? 8'h03 : 8'h30, 1'b0, 16'h0, 1'b0);
    step(8'h0C, 1'b0, 16'h0, 1'b0);
    idle(3);
    check("shoot_saturated", shoot_cnt, CMAX);

    // Reset in the middle of a deion pulse.
    step(8'h02, 1'b1, 16'h0100, 1'b0);
    step(8'h02, 1'b1, 16'h0100, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midpulse_reset_outputs", {fault, fault_leg, fault_type, shoot_cnt, dead_viol_cnt, pulse_cnt, peak_current, peak_valid}, 0);
    check("midpulse_reset_gate_kill", gate_kill, 0);
    check("peak_drain", peak_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_drive_monitor.md
Name: gate_drive_monitor

Overview:
Independent checker on the MOSFET gate command bus driven by the discharge pulse generator. It monitors the four half-bridge legs (buck1, buck2, res1, res2) and the deion switch. It detects shoot-through and dead-time violations, latches a sticky fault with a gate-kill output, and keeps saturating fault counters plus a discharge pulse counter. It sits between the pulse generator and the gate-driver pins, and its gate_kill feeds the pin-level AND mask.

Parameters:
DEAD_TIME_MIN, 16'd10, minimum all-off cycles required between one device of a leg turning off and the opposite device of the same leg turning on.
CNT_W, 16, width of the fault and pulse counters.

Ports:
clk  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
gate_buck1  in  2  buck1 leg command, {up, down}
gate_buck2  in  2  buck2 leg command, {up, down}
gate_res1  in  2  res1 leg command, {up, down}
gate_res2  in  2  res2 leg command, {up, down}
gate_deion  in  1  deionisation switch command
sample_current  in  16  signed ADC current sample (used only by the optional feature)
fault_clear  in  1  single-cycle request to clear the latched fault
fault  out  1  sticky fault flag
gate_kill  out  1  force-off request to the pin mask; equals fault
fault_leg  out  4  sticky bitmap of offending legs: bit0 buck1, bit1 buck2, bit2 res1, bit3 res2
fault_type  out  2  sticky fault types: bit0 shoot-through, bit1 dead-time violation
shoot_cnt  out  CNT_W  shoot-through event count, saturating
dead_viol_cnt  out  CNT_W  dead-time violation event count, saturating
pulse_cnt  out  CNT_W  count of gate_deion rising edges, wrapping
peak_current  out  16  per-pulse peak current (optional feature)
peak_valid  out  1  one-cycle strobe for peak_current (optional feature)

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, every leg FSM is in L_IDLE, and all counters are 0.
- All gate inputs are registered once (stage 1). The leg FSM and the fault logic evaluate stage 1. fault, fault_leg, fault_type and counters update on the next edge, two rising edges after the offending value appears at the ports.
- Per-leg FSM states: L_IDLE, L_UP, L_DN, L_DEAD_U, L_DEAD_D. dcnt is a 16-bit counter.
  - L_IDLE: 10 -> L_UP; 01 -> L_DN; 00 -> stay.
  - L_UP: 00 -> L_DEAD_U with dcnt=1; 10 -> stay; 01 -> dead-time violation, go to L_DN.
  - L_DN: mirror of L_UP.
  - L_DEAD_U: 00 -> dcnt++, and when dcnt reaches DEAD_TIME_MIN go to L_IDLE. 10 -> L_UP, no violation (same device). 01 with dcnt < DEAD_TIME_MIN -> violation, go to L_DN.
  - L_DEAD_D: mirror of L_DEAD_U.
  - Any state, 11 -> shoot-through event; the FSM goes to L_IDLE with dcnt=0 after the input leaves 11.
- Event definitions:
  - Shoot-through counts once per entry into 11, not per cycle held.
  - A violation counts once per offending transition.
  - Events on several legs in the same cycle: all fault_leg bits are set, and each counter increments by 1 per cycle regardless of the number of legs.
- Fault latch:
  - fault is set on any event and stays set.
  - fault_clear with no event in the same cycle clears fault, fault_leg and fault_type. Counters are not cleared.
  - A new event in the same cycle as fault_clear wins: fault stays 1 and the new bits are ORed in.
- Counters:
  - shoot_cnt and dead_viol_cnt saturate at 2^CNT_W-1.
  - pulse_cnt wraps modulo 2^CNT_W.
- gate_deion is never fault-checked.
- Reset asserted mid-pulse returns everything to the reset state immediately.

Optional Feature:
GATE_MON_PEAK_EN
- Defined:
  - A tracker resets to 0x8000 on the falling edge of stage-1 gate_deion (discharge start) and keeps the signed maximum of sample_current until the rising edge of gate_deion.
  - On that rising edge, peak_current takes the max and peak_valid pulses high for one cycle.
  - If gate_deion is already high out of reset, no strobe fires until a full low-then-high cycle has completed.
- Undefined: peak_current=0, peak_valid=0, sample_current unused.

Decomposition:
- Package gate_mon_pkg holds:
  - the leg state encodings;
  - the FT_SHOOT=0 and FT_DEAD=1 bit indices;
  - the leg indices LEG_BUCK1..LEG_RES2;
  - the NUM_LEGS=4 constant.
- Sub-module gate_leg_checker contains one leg FSM plus dcnt, with outputs shoot_evt and dead_evt. It is instantiated four times. Aggregation, counters and the latch live in the top level.

Test Plan:
- Legal sequence on buck1: 10 for 40 cycles, 00 for 10, then 01 -> fault stays 0 and both counters stay 0.
- res1 goes 10, then 00 for 5 cycles, then 01 (DEAD_TIME_MIN=10) -> fault=1 two edges after the 01, fault_leg=4'b0100, fault_type=2'b10, dead_viol_cnt=1.
- buck2 held at 11 for 7 cycles -> shoot_cnt=1 (not 7), fault_type bit0=1, gate_kill=1.
- fault_clear pulsed while buck1 and res2 hit 11 in the same cycle -> fault stays 1, fault_leg=4'b1001, shoot_cnt+1.
- 3 deion low/high cycles with sample_current peaks 120, -5 and 300 (PEAK_EN defined) -> pulse_cnt=3, with peak_valid strobes carrying 120, -5 and 300.
- Drive shoot_cnt to 0xFFFF, inject one more shoot-through, then assert rst_n low mid-pulse -> the count holds at 0xFFFF, then all outputs read 0 immediately after reset.
